// File: rtl/seq_mpy_pkg.sv
// Shared arithmetic-unit constants: function-select codes and the
// sequential multiplier state encoding.
package seq_mpy_pkg;

    // Function-select codes common to the ALU and the arithmetic units
    localparam logic [4:0] FsMulSigned   = 5'h1E;
    localparam logic [4:0] FsMulUnsigned = 5'h1D;

    // Sequential multiplier control states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2
    } mpy_state_e;

    // True when the function-select code is one the multiplier handles
    function automatic logic fs_is_mul(input logic [4:0] fs);
        return (fs == FsMulSigned) || (fs == FsMulUnsigned);
    endfunction

endpackage

// File: rtl/seq_mpy.sv
// Radix-2 sequential shift-add multiplier, signed or unsigned, producing an
// exact 2*WIDTH product with negative and zero flags after WIDTH+1 cycles.
module seq_mpy
    import seq_mpy_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       FS,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] T,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y_hi,
    output logic [WIDTH-1:0] Y_lo,
    output logic             N,
    output logic             Z
);

    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    mpy_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             neg_q, neg_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] y_hi_q, y_hi_d;
    logic [WIDTH-1:0] y_lo_q, y_lo_d;
    logic             n_q, n_d;
    logic             z_q, z_d;
    logic             done_q, done_d;

    logic             is_signed;
    logic             fs_ok;
    logic [WIDTH-1:0] s_mag;
    logic [WIDTH-1:0] t_mag;
    logic [PW-1:0]    prod;

    assign is_signed = (FS == FsMulSigned);
    assign fs_ok     = fs_is_mul(FS);

    // Magnitudes: -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned
    assign s_mag = (is_signed && S[WIDTH-1]) ? ({WIDTH{1'b0}} - S) : S;
    assign t_mag = (is_signed && T[WIDTH-1]) ? ({WIDTH{1'b0}} - T) : T;

    // Re-apply the result sign to the magnitude product
    assign prod = neg_q ? ({PW{1'b0}} - acc_q) : acc_q;

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        sgn_d    = sgn_q;
        y_hi_d   = y_hi_q;
        y_lo_d   = y_lo_q;
        n_d      = n_q;
        z_d      = z_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Unsupported codes leave every register untouched
                if (start && fs_ok) begin
                    sgn_d    = is_signed;
                    neg_d    = is_signed & (S[WIDTH-1] ^ T[WIDTH-1]);
                    mcand_d  = {{WIDTH{1'b0}}, s_mag};
                    mplier_d = t_mag;
                    acc_d    = '0;
                    cnt_d    = CntW'(WIDTH);
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                y_hi_d  = prod[PW-1:WIDTH];
                y_lo_d  = prod[WIDTH-1:0];
                n_d     = sgn_q & prod[PW-1];
                z_d     = (prod == '0);
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            sgn_q    <= 1'b0;
            y_hi_q   <= '0;
            y_lo_q   <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            sgn_q    <= sgn_d;
            y_hi_q   <= y_hi_d;
            y_lo_q   <= y_lo_d;
            n_q      <= n_d;
            z_q      <= z_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign Y_hi = y_hi_q;
    assign Y_lo = y_lo_q;
    assign N    = n_q;
    assign Z    = z_q;

endmodule

// File: tb/tb_seq_mpy.sv
// Directed self-checking bench for seq_mpy: a 32-bit and an 8-bit instance.
module tb_seq_mpy;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        start  = 1'b0;
    logic        start8 = 1'b0;
    logic [4:0]  FS     = 5'h00;
    logic [31:0] S      = '0;
    logic [31:0] T      = '0;
    logic [7:0]  S8     = '0;
    logic [7:0]  T8     = '0;

    logic        busy, done, N, Z;
    logic [31:0] Y_hi, Y_lo;
    logic        busy8, done8, N8, Z8;
    logic [7:0]  Y_hi8, Y_lo8;

    int errors = 0;
    int checks = 0;
    int lat;
    int seen;

    always #5 clk = ~clk;

    seq_mpy #(.WIDTH(32)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .FS   (FS),
        .S    (S),
        .T    (T),
        .busy (busy),
        .done (done),
        .Y_hi (Y_hi),
        .Y_lo (Y_lo),
        .N    (N),
        .Z    (Z)
    );

    seq_mpy #(.WIDTH(8)) dut8 (
        .clk  (clk),
        .reset(reset),
        .start(start8),
        .FS   (FS),
        .S    (S8),
        .T    (T8),
        .busy (busy8),
        .done (done8),
        .Y_hi (Y_hi8),
        .Y_lo (Y_lo8),
        .N    (N8),
        .Z    (Z8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start a 32-bit operation; lat = number of edges after the start edge until done
    task automatic run32(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t,
                         output int l);
        @(negedge clk);
        start = 1'b1;
        FS    = fs;
        S     = s;
        T     = t;
        @(posedge clk);
        #1;
        start = 1'b0;
        l = 0;
        while (!done && l < 100) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic run8(input logic [4:0] fs, input logic [7:0] s, input logic [7:0] t,
                        output int l);
        @(negedge clk);
        start8 = 1'b1;
        FS     = fs;
        S8     = s;
        T8     = t;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        l = 0;
        while (!done8 && l < 100) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    // Unsupported FS with start: no activity, registered results unchanged
    task automatic bad_fs_probe(input string tag, input logic [31:0] hi, input logic [31:0] lo,
                                input logic n, input logic z);
        int act;
        act = 0;
        @(negedge clk);
        start = 1'b1;
        FS    = 5'h05;
        S     = 32'hDEAD_BEEF;
        T     = 32'h0000_0003;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (busy || done) act++;
        end
        check({tag, "_activity"}, act, 0);
        check({tag, "_hold"}, {Y_hi, Y_lo}, {hi, lo});
        check({tag, "_nz"}, {N, Z}, {n, z});
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy_done", {busy, done}, 2'b00);
        check("rst_y", {Y_hi, Y_lo}, 64'h0);
        check("rst_nz", {N, Z}, 2'b00);
        check("rst8_all", {busy8, done8, N8, Z8, Y_hi8, Y_lo8}, '0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 7 * -3 signed
        run32(5'h1E, 32'h0000_0007, 32'hFFFF_FFFD, lat);
        check("s7xm3_lat", lat, 33);
        check("s7xm3_y", {Y_hi, Y_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        check("s7xm3_nz", {N, Z}, 2'b10);
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 1'b0);
        check("busy_after_done", busy, 1'b0);

        // All-ones, unsigned then signed
        run32(5'h1D, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("u_ones_y", {Y_hi, Y_lo}, 64'hFFFF_FFFE_0000_0001);
        check("u_ones_n", N, 1'b0);
        bad_fs_probe("badfs_nz", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        run32(5'h1E, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("s_ones_y", {Y_hi, Y_lo}, 64'h0000_0000_0000_0001);
        check("s_ones_n", N, 1'b0);

        // Most-negative squared
        run32(5'h1E, 32'h8000_0000, 32'h8000_0000, lat);
        check("s_minsq_y", {Y_hi, Y_lo}, 64'h4000_0000_0000_0000);
        check("s_minsq_nz", {N, Z}, 2'b00);

        // 8-bit instance
        run8(5'h1E, 8'h80, 8'h80, lat);
        check("w8_minsq_lat", lat, 9);
        check("w8_minsq_y", {Y_hi8, Y_lo8}, 16'h4000);
        run8(5'h1E, 8'hFD, 8'h05, lat);
        check("w8_m3x5_y", {Y_hi8, Y_lo8}, 16'hFFF1);
        check("w8_m3x5_nz", {N8, Z8}, 2'b10);
        run8(5'h1D, 8'hFF, 8'hFF, lat);
        check("w8_u_ones_y", {Y_hi8, Y_lo8}, 16'hFE01);
        check("w8_u_ones_n", N8, 1'b0);

        // Zero product, then unsupported FS
        run32(5'h1E, 32'h0000_0000, 32'h1234_5678, lat);
        check("zero_y", {Y_hi, Y_lo}, 64'h0);
        check("zero_nz", {N, Z}, 2'b01);
        bad_fs_probe("badfs_zero", 32'h0, 32'h0, 1'b0, 1'b1);

        // Start re-pulsed mid-operation is ignored
        @(negedge clk);
        start = 1'b1;
        FS    = 5'h1E;
        S     = 32'd5;
        T     = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_in_calc", busy, 1'b1);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 10) begin
                start = 1'b1;
                FS    = 5'h1D;
                S     = 32'd9;
                T     = 32'd9;
            end else begin
                start = 1'b0;
            end
        end
        check("restart_lat", lat, 33);
        check("restart_y", {Y_hi, Y_lo}, 64'd30);

        // Back-to-back start in the done cycle
        run32(5'h1D, 32'd3, 32'd5, lat);
        check("b2b_lat", lat, 33);
        check("b2b_y", {Y_hi, Y_lo}, 64'd15);

        // Asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1;
        FS    = 5'h1E;
        S     = 32'd2;
        T     = 32'hFFFF_FFF9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy_done", {busy, done}, 2'b00);
        check("arst_y", {Y_hi, Y_lo}, 64'h0);
        check("arst_nz", {N, Z}, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        check("arst_no_done", seen, 0);
        run32(5'h1E, 32'd3, 32'd4, lat);
        check("post_rst_lat", lat, 33);
        check("post_rst_y", {Y_hi, Y_lo}, 64'h0000_0000_0000_000C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
